mc_control_unit: RTL and testbench

Multicycle MIPS-1 main controller: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It sits directly upstream of the ALU and drives `AluControl_o`, operand-select and write-enable controls to the datapath. It consumes the ALU `Zero` flag to resolve branches. It also counts retired instructions.

---
 rtl/mc_control_unit_if.sv | 33 +++
 rtl/mc_control_unit.sv | 152 +++++++++++++++
 tb/tb_mc_control_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_if.sv
// Controller <-> datapath control bus for the multicycle MIPS-1 core.
// The master side is the controller; the slave side is the datapath and instruction register.
interface mc_control_unit_if;
   logic [5:0]  Op_i;
   logic [5:0]  Funct_i;
   logic        Zero_i;
   logic [2:0]  AluControl_o;
   logic        AluSrcA_o;
   logic [1:0]  AluSrcB_o;
   logic [1:0]  PCSrc_o;
   logic        IorD_o;
   logic        IRWrite_o;
   logic        MemWrite_o;
   logic        RegWrite_o;
   logic        RegDst_o;
   logic        MemtoReg_o;
   logic        PCEn_o;
   logic        IllegalInstr_o;
   logic [31:0] InstrCnt_o;

   modport master (
      input  Op_i, Funct_i, Zero_i,
      output AluControl_o, AluSrcA_o, AluSrcB_o, PCSrc_o, IorD_o, IRWrite_o,
             MemWrite_o, RegWrite_o, RegDst_o, MemtoReg_o, PCEn_o,
             IllegalInstr_o, InstrCnt_o
   );
   modport slave (
      output Op_i, Funct_i, Zero_i,
      input  AluControl_o, AluSrcA_o, AluSrcB_o, PCSrc_o, IorD_o, IRWrite_o,
             MemWrite_o, RegWrite_o, RegDst_o, MemtoReg_o, PCEn_o,
             IllegalInstr_o, InstrCnt_o
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-1 Moore controller with retired-instruction counter.
// Define MC_SLT_EN to decode funct 101010 as SLT; otherwise it is treated as illegal.
module mc_control_unit (
   input  logic              clk_i,
   input  logic              rst_i,
   mc_control_unit_if.master bus
);
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
   localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                          ALU_OR = 3'b001, ALU_SLT = 3'b111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
   } state_t;

   state_t      state, next, ostate;
   logic        funct_ok, op_ok, retire;
   logic [2:0]  funct_alu;
   logic        pc_write, branch, ir_write, mem_write, reg_write;
   logic [31:0] cnt;

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (bus.Funct_i)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
`ifdef MC_SLT_EN
         6'b101010: funct_alu = ALU_SLT;
`endif
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      case (bus.Op_i)
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
         OP_RT:   op_ok = funct_ok;
         default: op_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= FETCH;
      else       state <= next;
   end

   always_comb begin
      next = FETCH;
      case (state)
         FETCH:   next = DECODE;
         DECODE: begin
            if (op_ok) begin
               case (bus.Op_i)
                  OP_LW, OP_SW: next = MEMADR;
                  OP_RT:        next = RTYPEEX;
                  OP_BEQ:       next = BEQEX;
                  OP_ADDI:      next = ADDIEX;
                  OP_J:         next = JEX;
                  default:      next = FETCH;
               endcase
            end
         end
         MEMADR:  next = (bus.Op_i == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   next = MEMWB;
         RTYPEEX: next = RTYPEWB;
         ADDIEX:  next = ADDIWB;
         default: next = FETCH;
      endcase
   end

   assign retire = !rst_i && (state == MEMWB || state == MEMWR || state == RTYPEWB ||
                              state == BEQEX || state == ADDIWB || state == JEX);

   always_ff @(posedge clk_i) begin
      if (rst_i)       cnt <= '0;
      else if (retire) cnt <= cnt + 32'd1;
   end
   assign bus.InstrCnt_o = cnt;

   // Under reset the outputs look like FETCH, with every write enable masked below.
   assign ostate = rst_i ? FETCH : state;

   always_comb begin
      bus.AluControl_o   = ALU_ADD;
      bus.AluSrcA_o      = 1'b0;
      bus.AluSrcB_o      = 2'b00;
      bus.PCSrc_o        = 2'b00;
      bus.IorD_o         = 1'b0;
      bus.RegDst_o       = 1'b0;
      bus.MemtoReg_o     = 1'b0;
      bus.IllegalInstr_o = 1'b0;
      ir_write           = 1'b0;
      mem_write          = 1'b0;
      reg_write          = 1'b0;
      pc_write           = 1'b0;
      branch             = 1'b0;
      case (ostate)
         FETCH: begin
            ir_write      = 1'b1;
            bus.AluSrcB_o = 2'b01;
            pc_write      = 1'b1;
         end
         DECODE: begin
            bus.AluSrcB_o      = 2'b11;
            bus.IllegalInstr_o = !op_ok;
         end
         MEMADR, ADDIEX: begin
            bus.AluSrcA_o = 1'b1;
            bus.AluSrcB_o = 2'b10;
         end
         MEMRD: bus.IorD_o = 1'b1;
         MEMWB: begin
            bus.MemtoReg_o = 1'b1;
            reg_write      = 1'b1;
         end
         MEMWR: begin
            bus.IorD_o = 1'b1;
            mem_write  = 1'b1;
         end
         RTYPEEX: begin
            bus.AluSrcA_o    = 1'b1;
            bus.AluControl_o = funct_alu;
         end
         RTYPEWB: begin
            bus.RegDst_o = 1'b1;
            reg_write    = 1'b1;
         end
         BEQEX: begin
            bus.AluSrcA_o    = 1'b1;
            bus.AluControl_o = ALU_SUB;
            bus.PCSrc_o      = 2'b01;
            branch           = 1'b1;
         end
         ADDIWB: reg_write = 1'b1;
         JEX: begin
            bus.PCSrc_o = 2'b10;
            pc_write    = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.IRWrite_o  = ir_write  && !rst_i;
   assign bus.MemWrite_o = mem_write && !rst_i;
   assign bus.RegWrite_o = reg_write && !rst_i;
   assign bus.PCEn_o     = (pc_write || (branch && bus.Zero_i)) && !rst_i;
endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit: each instruction is expanded into its expected
// per-cycle control vectors and compared against the DUT on every cycle.
module tb_mc_control_unit;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                          BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

   typedef struct packed {
      logic [2:0] alu;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] pcsrc;
      logic       iord, irw, mw, rw, rd, m2r, pcw, br, ill;
   } cyc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   mc_control_unit_if bus ();

   mc_control_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] cnt    = '0;
   cyc_t        plan_q[$];
   bit          plan_retires;

   function automatic cyc_t blank();
      cyc_t c = '0;
      c.alu = 3'b010;
      return c;
   endfunction

   function automatic logic [3:0] fn_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 4'b1010;
         6'b100010: return 4'b1110;
         6'b100100: return 4'b1000;
         6'b100101: return 4'b1001;
`ifdef MC_SLT_EN
         6'b101010: return 4'b1111;
`endif
         default:   return 4'b0010;
      endcase
   endfunction

   // Expand one instruction into the control vector each of its cycles must show.
   function automatic void build(input logic [5:0] op, input logic [5:0] fn);
      cyc_t c;
      logic [3:0] fa = fn_alu(fn);
      bit legal = (op == LW) || (op == SW) || (op == BEQ) || (op == ADDI) || (op == J) ||
                  (op == RT && fa[3]);
      plan_q.delete();
      plan_retires = legal;
      c = blank(); c.irw = 1; c.srcb = 2'b01; c.pcw = 1; plan_q.push_back(c);
      c = blank(); c.srcb = 2'b11; c.ill = !legal; plan_q.push_back(c);
      if (!legal) return;
      if (op == LW || op == SW || op == ADDI) begin
         c = blank(); c.srca = 1; c.srcb = 2'b10; plan_q.push_back(c);
      end
      case (op)
         LW: begin
            c = blank(); c.iord = 1; plan_q.push_back(c);
            c = blank(); c.rw = 1; c.m2r = 1; plan_q.push_back(c);
         end
         SW: begin
            c = blank(); c.iord = 1; c.mw = 1; plan_q.push_back(c);
         end
         RT: begin
            c = blank(); c.srca = 1; c.alu = fa[2:0]; plan_q.push_back(c);
            c = blank(); c.rd = 1; c.rw = 1; plan_q.push_back(c);
         end
         BEQ: begin
            c = blank(); c.srca = 1; c.alu = 3'b110; c.pcsrc = 2'b01; c.br = 1;
            plan_q.push_back(c);
         end
         ADDI: begin
            c = blank(); c.rw = 1; plan_q.push_back(c);
         end
         J: begin
            c = blank(); c.pcsrc = 2'b10; c.pcw = 1; plan_q.push_back(c);
         end
         default: ;
      endcase
   endfunction

   function automatic logic [16:0] expv(input cyc_t c, input logic z);
      return {c.alu, c.srca, c.srcb, c.pcsrc, c.iord, c.irw, c.mw, c.rw, c.rd, c.m2r,
              c.pcw | (c.br & z), c.ill};
   endfunction

   function automatic logic [16:0] actv();
      return {bus.AluControl_o, bus.AluSrcA_o, bus.AluSrcB_o, bus.PCSrc_o, bus.IorD_o,
              bus.IRWrite_o, bus.MemWrite_o, bus.RegWrite_o, bus.RegDst_o, bus.MemtoReg_o,
              bus.PCEn_o, bus.IllegalInstr_o};
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic cyc_t rst_cyc();
      cyc_t c = blank();
      c.srcb = 2'b01;
      return c;
   endfunction

   // zf < 0 randomizes Zero_i each cycle; rst_at >= 0 asserts reset in that cycle.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input int rst_at, input int zf);
      logic z;
      build(op, fn);
      foreach (plan_q[i]) begin
         @(negedge clk);
         if (i == 0) begin
            bus.Op_i    = op;
            bus.Funct_i = fn;
         end
         z = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
         bus.Zero_i = z;
         rst = (i == rst_at);
         #1;
         check("ctl", {15'd0, actv()}, {15'd0, expv(rst ? rst_cyc() : plan_q[i], z)});
         check("cnt", bus.InstrCnt_o, cnt);
         if (rst) begin
            cnt = '0;
            return;
         end
      end
      if (plan_retires) cnt++;
   endtask

   initial begin
      logic [5:0] op, fn;
      int         r;
      bus.Op_i = '0; bus.Funct_i = '0; bus.Zero_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      repeat (2) begin
         @(negedge clk); #1;
         check("reset_ctl", {15'd0, actv()}, {15'd0, expv(rst_cyc(), bus.Zero_i)});
         check("reset_cnt", bus.InstrCnt_o, 32'd0);
      end

      run(LW, 6'h00, -1, -1);
      check("cpi_lw", plan_q.size(), 5);
      check("cnt_after_lw", cnt, 1);
      run(RT, 6'b100010, -1, -1);
      check("cpi_sub", plan_q.size(), 4);
      check("sub_alu", {29'd0, plan_q[2].alu}, 32'd6);
      run(BEQ, 6'h00, -1, 1);
      check("cpi_beq_taken", plan_q.size(), 3);
      run(BEQ, 6'h00, -1, 0);
      check("cnt_after_beq", cnt, 4);
      run(6'b111111, 6'h00, -1, -1);
      check("cpi_illegal", plan_q.size(), 2);
      check("cnt_after_illegal", cnt, 4);
      run(RT, 6'b101010, -1, -1);
`ifdef MC_SLT_EN
      check("cpi_slt", plan_q.size(), 4);
      check("cnt_after_slt", cnt, 5);
`else
      check("cpi_slt_illegal", plan_q.size(), 2);
      check("cnt_after_slt", cnt, 4);
`endif
      run(SW, 6'h00, 3, -1);
      check("cnt_after_sw_reset", cnt, 0);
      run(ADDI, 6'h00, -1, -1);
      run(J, 6'h00, -1, -1);
      check("cnt_after_addi_j", cnt, 2);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 7);
         case (r)
            0: op = LW;
            1: op = SW;
            2, 3: op = RT;
            4: op = BEQ;
            5: op = ADDI;
            6: op = J;
            default: op = 6'($urandom);
         endcase
         case ($urandom_range(0, 6))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            4: fn = 6'b101010;
            default: fn = 6'($urandom);
         endcase
         run(op, fn, ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 4)) : -1, -1);
      end

      @(negedge clk);
      rst = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
